nn_axil_slave: RTL and testbench
================================

NN_AXIL_SLAVE -- requirements
Module: nn_axil_slave

Interface
REQ-001 SHALL have parameters: C_S_AXI_DATA_WIDTH, 32, data bus width; C_S_AXI_ADDR_WIDTH, 5, byte-address width.
REQ-002 SHALL have ports, clock and reset first: s_axi_aclk in 1 clock; s_axi_aresetn in 1 asynchronous active-low reset.
REQ-003 s_axi_awaddr in 5 write address; s_axi_awprot in 3 ignored; s_axi_awvalid in 1; s_axi_awready out 1.
REQ-004 s_axi_wdata in 32; s_axi_wstrb in 4; s_axi_wvalid in 1; s_axi_wready out 1.
REQ-005 s_axi_bresp out 2; s_axi_bvalid out 1; s_axi_bready in 1.
REQ-006 s_axi_araddr in 5; s_axi_arprot in 3 ignored; s_axi_arvalid in 1; s_axi_arready out 1.
REQ-007 s_axi_rdata out 32; s_axi_rresp out 2; s_axi_rvalid out 1; s_axi_rready in 1.
REQ-008 weight_data out 32, weight_valid out 1 one-cycle pulse; bias_data out 32, bias_valid out 1 one-cycle pulse.
REQ-009 layer_num out 8; neuron_num out 16; soft_reset out 1 core reset, active-high.
REQ-010 result in 32 classifier output; result_valid in 1 pulse; intr out 1 level interrupt.

Function
REQ-011 Register map: 0x00 weight (WO), 0x04 bias (WO), 0x08 result (RO), 0x0C layer (RW), 0x10 neuron (RW), 0x14 status (RO), 0x18 int-enable (RW), 0x1C soft-reset (RW).
REQ-012 AW and W SHALL be captured independently into one-entry buffers; awready/wready high only while their buffer is empty and bvalid is low.
REQ-013 Edge after both buffers full: register write/pulse performed, buffers cleared, bvalid asserted.
REQ-014 bvalid SHALL hold with stable bresp until bready sampled high; no new AW/W accepted meanwhile.
REQ-015 Write with wstrb != 4'hF or unmapped/read-only address SHALL change no state, produce no pulse, return bresp 2'b10 (SLVERR).
REQ-016 Otherwise bresp SHALL be 2'b00.
REQ-017 Write to 0x00 SHALL drive weight_data=wdata and weight_valid=1 for exactly one cycle; 0x04 likewise for bias.
REQ-018 layer_num and neuron_num SHALL take wdata[7:0] and wdata[15:0]; int-enable takes wdata[0]; soft_reset takes wdata[0].
REQ-019 arready SHALL be high only when rvalid is low; read accepted at edge N yields rvalid and registered rdata at edge N+1.
REQ-020 rvalid/rdata/rresp SHALL hold until rready sampled high.
REQ-021 Unmapped or write-only read SHALL return rdata 0, rresp SLVERR; readable registers return zero-extended value, rresp OKAY.
REQ-022 result_valid SHALL capture result into 0x08 and set status bit0 (done).
REQ-023 intr SHALL equal done AND int-enable.
REQ-024 Accepted read of 0x08 SHALL clear done at the acceptance edge.
REQ-025 result_valid coinciding with read acceptance of 0x08: read returns old value, new result stored, done remains set.
REQ-026 status bit1 SHALL reflect soft_reset; bits 31:2 read 0.
REQ-027 Simultaneous read and write SHALL proceed independently; write to 0x18 takes effect on intr the following cycle.

Reset
REQ-028 Asynchronous assertion of s_axi_aresetn low SHALL immediately clear all ready/valid outputs, pulses, buffers, registers, done, intr.
REQ-029 Reset values: soft_reset 1, layer_num 0, neuron_num 0, int-enable 1, result 0, bresp/rresp 0, rdata 0.
REQ-030 Reset mid-transaction SHALL abandon it; no pulse or response issued after release.
REQ-031 Release SHALL be synchronised to s_axi_aclk; first handshake accepted no earlier than second edge after release.

Structure
REQ-032 Register offsets, response codes and field widths SHALL live in shared package nn_axil_pkg.
REQ-033 Single module, no sub-modules; read mux and write decode inline.

Verification
REQ-034 Write 0x1C=0, then read 0x14 -> soft_reset 0, rdata 0x00000000, bresp/rresp OKAY.
REQ-035 W (0x00, 0x0000ABCD) two cycles before AW -> one weight_valid pulse, weight_data 0x0000ABCD, one bvalid.
REQ-036 Write 0x08 and wstrb 4'h3 to 0x10 -> both SLVERR, neuron_num unchanged 0, no pulses.
REQ-037 result_valid with result 7, int-enable 1 -> intr 1; read 0x08 -> rdata 7, intr 0 next cycle.
REQ-038 bready/rready held low 10 cycles -> bvalid/rvalid and data stable, awready/arready low throughout.
REQ-039 Assert s_axi_aresetn low while bvalid pending -> bvalid 0 immediately, soft_reset 1, no response after release.

Source files
------------

// File: rtl/nn_axil_pkg.sv
// Shared register map, response codes and field widths for the NN core
// AXI4-Lite control slave.
package nn_axil_pkg;

   localparam int unsigned ADDR_W   = 5;
   localparam int unsigned LAYER_W  = 8;
   localparam int unsigned NEURON_W = 16;

   localparam logic [ADDR_W-1:0] REG_WEIGHT = 5'h00;
   localparam logic [ADDR_W-1:0] REG_BIAS   = 5'h04;
   localparam logic [ADDR_W-1:0] REG_RESULT = 5'h08;
   localparam logic [ADDR_W-1:0] REG_LAYER  = 5'h0C;
   localparam logic [ADDR_W-1:0] REG_NEURON = 5'h10;
   localparam logic [ADDR_W-1:0] REG_STATUS = 5'h14;
   localparam logic [ADDR_W-1:0] REG_INTEN  = 5'h18;
   localparam logic [ADDR_W-1:0] REG_SRST   = 5'h1C;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   // Unaligned offsets fall through to default and are treated as unmapped.
   function automatic logic reg_writable(input logic [ADDR_W-1:0] a);
      case (a)
         REG_WEIGHT, REG_BIAS, REG_LAYER, REG_NEURON, REG_INTEN, REG_SRST: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/nn_axil_slave.sv
// AXI4-Lite control/status slave for the NN core: weight/bias streaming
// pulses, layer/neuron selection, result capture with done interrupt.
module nn_axil_slave
   import nn_axil_pkg::*;
#(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 5
) (
   input  logic                            s_axi_aclk,
   input  logic                            s_axi_aresetn,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
   input  logic [2:0]                      s_axi_awprot,
   input  logic                            s_axi_awvalid,
   output logic                            s_axi_awready,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
   input  logic                            s_axi_wvalid,
   output logic                            s_axi_wready,
   output logic [1:0]                      s_axi_bresp,
   output logic                            s_axi_bvalid,
   input  logic                            s_axi_bready,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
   input  logic [2:0]                      s_axi_arprot,
   input  logic                            s_axi_arvalid,
   output logic                            s_axi_arready,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
   output logic [1:0]                      s_axi_rresp,
   output logic                            s_axi_rvalid,
   input  logic                            s_axi_rready,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   weight_data,
   output logic                            weight_valid,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   bias_data,
   output logic                            bias_valid,
   output logic [LAYER_W-1:0]              layer_num,
   output logic [NEURON_W-1:0]             neuron_num,
   output logic                            soft_reset,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   result,
   input  logic                            result_valid,
   output logic                            intr
);

   localparam int DW = C_S_AXI_DATA_WIDTH;
   localparam int SW = C_S_AXI_DATA_WIDTH / 8;

   logic [1:0]        en_q, en_d;
   logic              aw_full_q, aw_full_d;
   logic [ADDR_W-1:0] aw_addr_q, aw_addr_d;
   logic              w_full_q, w_full_d;
   logic [DW-1:0]     w_data_q, w_data_d;
   logic [SW-1:0]     w_strb_q, w_strb_d;
   logic              bvalid_q, bvalid_d;
   logic [1:0]        bresp_q, bresp_d;
   logic              rvalid_q, rvalid_d;
   logic [DW-1:0]     rdata_q, rdata_d;
   logic [1:0]        rresp_q, rresp_d;
   logic [DW-1:0]     weight_q, weight_d;
   logic              wvld_q, wvld_d;
   logic [DW-1:0]     bias_q, bias_d;
   logic              bvld_q, bvld_d;
   logic [LAYER_W-1:0]  layer_q, layer_d;
   logic [NEURON_W-1:0] neuron_q, neuron_d;
   logic              inten_q, inten_d;
   logic              srst_q, srst_d;
   logic [DW-1:0]     result_q, result_d;
   logic              done_q, done_d;

   logic              aw_hs, w_hs, ar_hs, wr_go, wr_ok;
   logic [ADDR_W-1:0] ar_addr;
   logic [DW-1:0]     rd_data;
   logic [1:0]        rd_resp;
   logic              unused_prot;

   assign unused_prot = ^{s_axi_awprot, s_axi_arprot};

   // en_q[1] rises on the second edge after reset release; no handshake before that.
   assign s_axi_awready = en_q[1] & ~aw_full_q & ~bvalid_q;
   assign s_axi_wready  = en_q[1] & ~w_full_q  & ~bvalid_q;
   assign s_axi_arready = en_q[1] & ~rvalid_q;

   assign aw_hs   = s_axi_awvalid & s_axi_awready;
   assign w_hs    = s_axi_wvalid  & s_axi_wready;
   assign ar_hs   = s_axi_arvalid & s_axi_arready;
   assign ar_addr = s_axi_araddr[ADDR_W-1:0];
   assign wr_go   = aw_full_q & w_full_q;
   assign wr_ok   = wr_go & reg_writable(aw_addr_q) & (w_strb_q == {SW{1'b1}});

   always_comb begin
      rd_data = '0;
      rd_resp = RESP_OKAY;
      case (ar_addr)
         REG_RESULT: rd_data = result_q;
         REG_LAYER:  rd_data[LAYER_W-1:0] = layer_q;
         REG_NEURON: rd_data[NEURON_W-1:0] = neuron_q;
         REG_STATUS: rd_data[1:0] = {srst_q, done_q};
         REG_INTEN:  rd_data[0] = inten_q;
         REG_SRST:   rd_data[0] = srst_q;
         default:    rd_resp = RESP_SLVERR;
      endcase
   end

   always_comb begin
      en_d      = {en_q[0], 1'b1};
      aw_full_d = aw_full_q;
      aw_addr_d = aw_addr_q;
      w_full_d  = w_full_q;
      w_data_d  = w_data_q;
      w_strb_d  = w_strb_q;
      bvalid_d  = bvalid_q;
      bresp_d   = bresp_q;
      rvalid_d  = rvalid_q;
      rdata_d   = rdata_q;
      rresp_d   = rresp_q;
      weight_d  = weight_q;
      wvld_d    = 1'b0;
      bias_d    = bias_q;
      bvld_d    = 1'b0;
      layer_d   = layer_q;
      neuron_d  = neuron_q;
      inten_d   = inten_q;
      srst_d    = srst_q;
      result_d  = result_q;
      done_d    = done_q;

      if (aw_hs) begin
         aw_full_d = 1'b1;
         aw_addr_d = s_axi_awaddr[ADDR_W-1:0];
      end
      if (w_hs) begin
         w_full_d = 1'b1;
         w_data_d = s_axi_wdata;
         w_strb_d = s_axi_wstrb;
      end

      if (wr_go) begin
         aw_full_d = 1'b0;
         w_full_d  = 1'b0;
         bvalid_d  = 1'b1;
         bresp_d   = wr_ok ? RESP_OKAY : RESP_SLVERR;
         if (wr_ok) begin
            case (aw_addr_q)
               REG_WEIGHT: begin weight_d = w_data_q; wvld_d = 1'b1; end
               REG_BIAS:   begin bias_d = w_data_q; bvld_d = 1'b1; end
               REG_LAYER:  layer_d  = w_data_q[LAYER_W-1:0];
               REG_NEURON: neuron_d = w_data_q[NEURON_W-1:0];
               REG_INTEN:  inten_d  = w_data_q[0];
               REG_SRST:   srst_d   = w_data_q[0];
               default: ;
            endcase
         end
      end else if (bvalid_q && s_axi_bready) begin
         bvalid_d = 1'b0;
      end

      if (ar_hs) begin
         rvalid_d = 1'b1;
         rdata_d  = rd_data;
         rresp_d  = rd_resp;
         if (ar_addr == REG_RESULT) done_d = 1'b0;
      end else if (rvalid_q && s_axi_rready) begin
         rvalid_d = 1'b0;
      end

      // A new result wins over a same-edge read-clear so it is never lost.
      if (result_valid) begin
         result_d = result;
         done_d   = 1'b1;
      end
   end

   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         en_q      <= '0;
         aw_full_q <= 1'b0;
         aw_addr_q <= '0;
         w_full_q  <= 1'b0;
         w_data_q  <= '0;
         w_strb_q  <= '0;
         bvalid_q  <= 1'b0;
         bresp_q   <= RESP_OKAY;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
         rresp_q   <= RESP_OKAY;
         weight_q  <= '0;
         wvld_q    <= 1'b0;
         bias_q    <= '0;
         bvld_q    <= 1'b0;
         layer_q   <= '0;
         neuron_q  <= '0;
         inten_q   <= 1'b1;
         srst_q    <= 1'b1;
         result_q  <= '0;
         done_q    <= 1'b0;
      end else begin
         en_q      <= en_d;
         aw_full_q <= aw_full_d;
         aw_addr_q <= aw_addr_d;
         w_full_q  <= w_full_d;
         w_data_q  <= w_data_d;
         w_strb_q  <= w_strb_d;
         bvalid_q  <= bvalid_d;
         bresp_q   <= bresp_d;
         rvalid_q  <= rvalid_d;
         rdata_q   <= rdata_d;
         rresp_q   <= rresp_d;
         weight_q  <= weight_d;
         wvld_q    <= wvld_d;
         bias_q    <= bias_d;
         bvld_q    <= bvld_d;
         layer_q   <= layer_d;
         neuron_q  <= neuron_d;
         inten_q   <= inten_d;
         srst_q    <= srst_d;
         result_q  <= result_d;
         done_q    <= done_d;
      end
   end

   assign s_axi_bvalid = bvalid_q;
   assign s_axi_bresp  = bresp_q;
   assign s_axi_rvalid = rvalid_q;
   assign s_axi_rdata  = rdata_q;
   assign s_axi_rresp  = rresp_q;
   assign weight_data  = weight_q;
   assign weight_valid = wvld_q;
   assign bias_data    = bias_q;
   assign bias_valid   = bvld_q;
   assign layer_num    = layer_q;
   assign neuron_num   = neuron_q;
   assign soft_reset   = srst_q;
   assign intr         = done_q & inten_q;

endmodule

// File: tb/tb_nn_axil_slave.sv
// Directed bench for nn_axil_slave: register map, handshakes, back-pressure,
// result/interrupt behaviour and asynchronous reset.
module tb_nn_axil_slave;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [4:0]  awaddr = '0;
   logic [2:0]  awprot = '0;
   logic        awvalid = 1'b0;
   logic        awready;
   logic [31:0] wdata = '0;
   logic [3:0]  wstrb = '0;
   logic        wvalid = 1'b0;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready = 1'b0;
   logic [4:0]  araddr = '0;
   logic [2:0]  arprot = '0;
   logic        arvalid = 1'b0;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready = 1'b0;
   logic [31:0] weight_data;
   logic        weight_valid;
   logic [31:0] bias_data;
   logic        bias_valid;
   logic [7:0]  layer_num;
   logic [15:0] neuron_num;
   logic        soft_reset;
   logic [31:0] result = '0;
   logic        result_valid = 1'b0;
   logic        intr;

   int n_checks = 0;
   int n_errors = 0;
   int wv_cnt = 0, bv_cnt = 0, b_cnt = 0;
   logic [31:0] wv_last = '0, bv_last = '0;
   logic bv_prev = 1'b0;

   logic [4:0]  rv_addr [6] = '{5'h0C, 5'h18, 5'h14, 5'h08, 5'h00, 5'h04};
   logic [31:0] rv_data [6] = '{32'h0, 32'h1, 32'h2, 32'h0, 32'h0, 32'h0};
   logic [1:0]  rv_resp [6] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b10};

   nn_axil_slave dut (
      .s_axi_aclk(clk), .s_axi_aresetn(rst_n),
      .s_axi_awaddr(awaddr), .s_axi_awprot(awprot), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
      .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
      .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
      .s_axi_araddr(araddr), .s_axi_arprot(arprot), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
      .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
      .weight_data(weight_data), .weight_valid(weight_valid),
      .bias_data(bias_data), .bias_valid(bias_valid),
      .layer_num(layer_num), .neuron_num(neuron_num), .soft_reset(soft_reset),
      .result(result), .result_valid(result_valid), .intr(intr)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (weight_valid) begin wv_cnt++; wv_last = weight_data; end
      if (bias_valid) begin bv_cnt++; bv_last = bias_data; end
      if (bvalid && !bv_prev) b_cnt++;
      bv_prev = bvalid;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic wr_send(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
      logic aw_acc, w_acc;
      awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
      for (int i = 0; i < 20 && (awvalid || wvalid); i++) begin
         aw_acc = awvalid & awready;
         w_acc  = wvalid & wready;
         @(posedge clk); #1;
         if (aw_acc) awvalid = 1'b0;
         if (w_acc) wvalid = 1'b0;
      end
      check("wr_accept", 32'(awvalid | wvalid), 0);
      awvalid = 1'b0; wvalid = 1'b0;
   endtask

   task automatic wr_resp(output logic [1:0] resp);
      logic got = 1'b0;
      resp = 2'bxx;
      bready = 1'b1;
      for (int i = 0; i < 20 && !got; i++) begin
         if (bvalid) begin resp = bresp; got = 1'b1; end
         @(posedge clk); #1;
      end
      bready = 1'b0;
      check("wr_bvalid", 32'(got), 1);
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s, output logic [1:0] resp);
      wr_send(a, d, s);
      wr_resp(resp);
   endtask

   task automatic rd_send(input logic [4:0] a);
      logic acc = 1'b0;
      araddr = a; arvalid = 1'b1;
      for (int i = 0; i < 20 && !acc; i++) begin
         acc = arready;
         @(posedge clk); #1;
      end
      arvalid = 1'b0;
      check("rd_accept", 32'(acc), 1);
   endtask

   task automatic rd_resp(output logic [31:0] d, output logic [1:0] resp);
      logic got = 1'b0;
      d = 'x; resp = 2'bxx;
      rready = 1'b1;
      for (int i = 0; i < 20 && !got; i++) begin
         if (rvalid) begin d = rdata; resp = rresp; got = 1'b1; end
         @(posedge clk); #1;
      end
      rready = 1'b0;
      check("rd_rvalid", 32'(got), 1);
   endtask

   task automatic rd(input logic [4:0] a, output logic [31:0] d, output logic [1:0] resp);
      rd_send(a);
      rd_resp(d, resp);
   endtask

   task automatic pulse_result(input logic [31:0] v);
      result = v; result_valid = 1'b1;
      @(posedge clk); #1;
      result_valid = 1'b0;
   endtask

   initial begin
      logic [1:0]  resp, resp2;
      logic [31:0] d, d2;
      int w0, b0, c0, hold;

      repeat (2) @(posedge clk); #1;
      check("rst_awready", 32'(awready), 0);
      check("rst_arready", 32'(arready), 0);
      check("rst_bvalid", 32'(bvalid), 0);
      check("rst_rvalid", 32'(rvalid), 0);
      check("rst_soft_reset", 32'(soft_reset), 1);
      check("rst_layer", 32'(layer_num), 0);
      check("rst_neuron", 32'(neuron_num), 0);
      check("rst_intr", 32'(intr), 0);
      check("rst_pulses", 32'({weight_valid, bias_valid}), 0);

      @(negedge clk); rst_n = 1'b1; #1;
      check("rel_awready", 32'(awready), 0);
      check("rel_arready", 32'(arready), 0);
      repeat (4) @(posedge clk); #1;
      check("run_awready", 32'(awready), 1);

      for (int i = 0; i < 6; i++) begin
         rd(rv_addr[i], d, resp);
         check($sformatf("rst_rd_%02h", rv_addr[i]), d, rv_data[i]);
         check($sformatf("rst_rresp_%02h", rv_addr[i]), 32'(resp), 32'(rv_resp[i]));
      end

      wr(5'h1C, 32'h0, 4'hF, resp);
      check("srst_bresp", 32'(resp), 0);
      check("srst_out", 32'(soft_reset), 0);
      rd(5'h14, d, resp);
      check("status_rd", d, 32'h0);
      check("status_rresp", 32'(resp), 0);

      w0 = wv_cnt; b0 = bv_cnt;
      wr(5'h08, 32'h1234, 4'hF, resp);
      check("ro_bresp", 32'(resp), 2);
      wr(5'h10, 32'h5555, 4'h3, resp);
      check("strb_bresp", 32'(resp), 2);
      wr(5'h02, 32'h5555, 4'hF, resp);
      check("unaligned_bresp", 32'(resp), 2);
      check("err_neuron", 32'(neuron_num), 0);
      check("err_pulses", wv_cnt - w0 + bv_cnt - b0, 0);

      w0 = wv_cnt; c0 = b_cnt;
      awaddr = 5'h00; wdata = 32'h0000ABCD; wstrb = 4'hF; wvalid = 1'b1;
      @(posedge clk); #1;
      wvalid = 1'b0;
      @(posedge clk); #1;
      awvalid = 1'b1;
      @(posedge clk); #1;
      awvalid = 1'b0;
      wr_resp(resp);
      repeat (2) @(posedge clk); #1;
      check("wfirst_bresp", 32'(resp), 0);
      check("wfirst_pulses", wv_cnt - w0, 1);
      check("wfirst_data", wv_last, 32'h0000ABCD);
      check("wfirst_bcount", b_cnt - c0, 1);

      b0 = bv_cnt;
      wr(5'h04, 32'hDEADBEEF, 4'hF, resp);
      repeat (2) @(posedge clk); #1;
      check("bias_pulses", bv_cnt - b0, 1);
      check("bias_data", bv_last, 32'hDEADBEEF);

      wr(5'h0C, 32'hFFFFFF05, 4'hF, resp);
      check("layer_out", 32'(layer_num), 32'h05);
      wr(5'h10, 32'hABCD1234, 4'hF, resp);
      check("neuron_out", 32'(neuron_num), 32'h1234);
      rd(5'h0C, d, resp);
      check("layer_rd", d, 32'h05);
      rd(5'h10, d, resp);
      check("neuron_rd", d, 32'h1234);

      pulse_result(32'd7);
      check("done_intr", 32'(intr), 1);
      rd(5'h14, d, resp);
      check("done_status", d, 32'h1);
      rd(5'h08, d, resp);
      check("result_rd", d, 32'd7);
      check("result_rresp", 32'(resp), 0);
      check("rdclr_intr", 32'(intr), 0);
      rd(5'h14, d, resp);
      check("rdclr_status", d, 32'h0);

      wr(5'h18, 32'h0, 4'hF, resp);
      pulse_result(32'd9);
      check("masked_intr", 32'(intr), 0);
      wr(5'h18, 32'h1, 4'hF, resp);
      check("unmask_intr", 32'(intr), 1);
      rd(5'h08, d, resp);
      check("result9_rd", d, 32'd9);
      check("result9_intr", 32'(intr), 0);

      fork
         wr(5'h18, 32'hFFFFFFFE, 4'hF, resp);
         rd(5'h10, d2, resp2);
      join
      check("par_bresp", 32'(resp), 0);
      check("par_rd", d2, 32'h1234);
      check("par_rresp", 32'(resp2), 0);
      rd(5'h18, d, resp);
      check("par_inten", d, 32'h0);
      wr(5'h18, 32'h1, 4'hF, resp);

      pulse_result(32'h22);
      check("pre_race_arready", 32'(arready), 1);
      araddr = 5'h08; arvalid = 1'b1; result = 32'h55; result_valid = 1'b1;
      @(posedge clk); #1;
      arvalid = 1'b0; result_valid = 1'b0;
      check("race_rdata", rdata, 32'h22);
      check("race_intr", 32'(intr), 1);
      rd_resp(d, resp);
      rd(5'h08, d, resp);
      check("race_new", d, 32'h55);
      check("race_clr_intr", 32'(intr), 0);

      wr_send(5'h0C, 32'h33, 4'hF);
      for (int i = 0; i < 10 && !bvalid; i++) begin @(posedge clk); #1; end
      hold = 0;
      for (int i = 0; i < 10; i++) begin
         if (bvalid && bresp == 2'b00 && !awready && !wready) hold++;
         @(posedge clk); #1;
      end
      check("bhold_cycles", hold, 10);
      wr_resp(resp);
      check("bhold_bresp", 32'(resp), 0);
      rd_send(5'h0C);
      hold = 0;
      for (int i = 0; i < 10; i++) begin
         if (rvalid && rdata == 32'h33 && rresp == 2'b00 && !arready) hold++;
         @(posedge clk); #1;
      end
      check("rhold_cycles", hold, 10);
      rd_resp(d, resp);
      check("rhold_rd", d, 32'h33);

      wr_send(5'h1C, 32'h0, 4'hF);
      for (int i = 0; i < 10 && !bvalid; i++) begin @(posedge clk); #1; end
      check("arst_pre_bvalid", 32'(bvalid), 1);
      c0 = b_cnt;
      #2 rst_n = 1'b0;
      #1;
      check("arst_bvalid", 32'(bvalid), 0);
      check("arst_soft_reset", 32'(soft_reset), 1);
      check("arst_layer", 32'(layer_num), 0);
      check("arst_awready", 32'(awready), 0);
      @(negedge clk); rst_n = 1'b1;
      bready = 1'b1;
      repeat (10) @(posedge clk); #1;
      bready = 1'b0;
      check("arst_no_resp", b_cnt - c0, 0);

      w0 = wv_cnt;
      awaddr = 5'h00; wdata = 32'h99; wstrb = 4'hF; wvalid = 1'b1;
      for (int i = 0; i < 10 && !wready; i++) begin @(posedge clk); #1; end
      @(posedge clk); #1;
      wvalid = 1'b0;
      #2 rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      repeat (4) @(posedge clk); #1;
      wr(5'h0C, 32'h44, 4'hF, resp);
      repeat (2) @(posedge clk); #1;
      check("abandon_layer", 32'(layer_num), 32'h44);
      check("abandon_pulses", wv_cnt - w0, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
